// File: rtl/axi_vga_flip_pkg.sv
// Shared types for the VGA frame-buffer flip scheduler.
package axi_vga_flip_pkg;

  localparam int unsigned MaxBufs = 4;

  typedef enum logic [1:0] {
    DISABLED,
    SYNC,
    RUN
  } flip_state_e;

endpackage

// File: rtl/axi_vga_edge_det.sv
// Polarity-normalised rising-edge detector; the reset value of the history
// register decides whether a level already active out of reset counts as an edge.
module axi_vga_edge_det
  import axi_vga_flip_pkg::*;
#(
  parameter logic RstVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_sig,
  input  logic i_pol,
  output logic o_edge_c
);

  logic w_act;
  logic r_q;

  assign w_act    = ~(i_sig ^ i_pol);
  assign o_edge_c = w_act & ~r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= RstVal;
    end else begin
      r_q <= w_act;
    end
  end

endmodule

// File: rtl/axi_vga_flip_ctrl.sv
// Frame-buffer flip scheduler: queues one flip request and applies it only at
// a vsync frame boundary, driving the fetcher start address and enable.
module axi_vga_flip_ctrl
  import axi_vga_flip_pkg::*;
#(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned NumBufs       = 3,
  parameter int unsigned IdxWidth      = $clog2(NumBufs),
  parameter int unsigned FrameCntWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         vsync_pol_i,
  input  logic                         vsync_i,
  input  logic [NumBufs*AddrWidth-1:0] buf_base_i,
  input  logic                         flip_req_i,
  input  logic [IdxWidth-1:0]          flip_idx_i,
  output logic [AddrWidth-1:0]         start_addr_o,
  output logic                         fetch_en_o,
  output logic                         frame_start_o,
  output logic [IdxWidth-1:0]          disp_idx_o,
  output logic                         pending_o,
  output logic                         flip_done_o,
  output logic                         flip_drop_o,
  output logic                         idx_err_o,
  output logic [FrameCntWidth-1:0]     frame_cnt_o
);

  localparam int unsigned NumSlots = 1 << IdxWidth;
  localparam logic [IdxWidth:0] NumBufsW = (IdxWidth + 1)'(NumBufs);

  flip_state_e              r_state;
  logic [AddrWidth-1:0]     r_start_addr;
  logic                     r_fetch_en;
  logic                     r_frame_start;
  logic [IdxWidth-1:0]      r_disp_idx;
  logic [IdxWidth-1:0]      r_pend_idx;
  logic                     r_pending;
  logic                     r_flip_done;
  logic                     r_flip_drop;
  logic                     r_idx_err;
  logic [FrameCntWidth-1:0] r_frame_cnt;

  logic                     w_boundary;
  logic                     w_idx_ok;
  logic [IdxWidth-1:0]      w_new_idx;
  logic [AddrWidth-1:0]     w_base [NumSlots];

  axi_vga_edge_det #(
    .RstVal (1'b1)
  ) u_vs_edge (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_sig    (vsync_i),
    .i_pol    (vsync_pol_i),
    .o_edge_c (w_boundary)
  );

  // Unpack bases into a power-of-two table so any index value selects a defined entry.
  for (genvar k = 0; k < NumSlots; k++) begin : g_base
    if (k < NumBufs) begin : g_used
      assign w_base[k] = buf_base_i[k*AddrWidth +: AddrWidth];
    end else begin : g_unused
      assign w_base[k] = '0;
    end
  end

  assign w_idx_ok  = {1'b0, flip_idx_i} < NumBufsW;
  assign w_new_idx = r_pending ? r_pend_idx : r_disp_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= DISABLED;
      r_start_addr  <= '0;
      r_fetch_en    <= 1'b0;
      r_frame_start <= 1'b0;
      r_disp_idx    <= '0;
      r_pend_idx    <= '0;
      r_pending     <= 1'b0;
      r_flip_done   <= 1'b0;
      r_flip_drop   <= 1'b0;
      r_idx_err     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_flip_done   <= 1'b0;
      r_flip_drop   <= 1'b0;
      r_idx_err     <= 1'b0;
      case (r_state)
        DISABLED: begin
          r_fetch_en <= 1'b0;
          r_pending  <= 1'b0;
          if (enable_i) r_state <= SYNC;
        end
        SYNC, RUN: begin
          if (!enable_i) begin
            r_state    <= DISABLED;
            r_fetch_en <= 1'b0;
            r_pending  <= 1'b0;
          end else begin
            if (w_boundary) begin
              r_state       <= RUN;
              r_disp_idx    <= w_new_idx;
              r_start_addr  <= w_base[w_new_idx];
              r_frame_start <= 1'b1;
              r_frame_cnt   <= r_frame_cnt + FrameCntWidth'(1);
              r_fetch_en    <= 1'b1;
              r_flip_done   <= r_pending;
              r_pending     <= 1'b0;
            end
            // A request on a boundary queues behind the flip being consumed, so it never drops.
            if (flip_req_i) begin
              if (!w_idx_ok) begin
                r_idx_err <= 1'b1;
              end else begin
                r_pend_idx  <= flip_idx_i;
                r_pending   <= 1'b1;
                r_flip_drop <= r_pending & ~w_boundary;
              end
            end
          end
        end
        default: r_state <= DISABLED;
      endcase
    end
  end

  assign start_addr_o  = r_start_addr;
  assign fetch_en_o    = r_fetch_en;
  assign frame_start_o = r_frame_start;
  assign disp_idx_o    = r_disp_idx;
  assign pending_o     = r_pending;
  assign flip_done_o   = r_flip_done;
  assign flip_drop_o   = r_flip_drop;
  assign idx_err_o     = r_idx_err;
  assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_axi_vga_flip_ctrl.sv
// Scoreboard bench for axi_vga_flip_ctrl: expectations are queued with each
// stimulus step and compared against the DUT outputs one cycle later.
module tb_axi_vga_flip_ctrl;

  localparam int unsigned AddrWidth     = 64;
  localparam int unsigned NumBufs       = 3;
  localparam int unsigned IdxWidth      = 2;
  localparam int unsigned FrameCntWidth = 4;

  logic                         clk_i = 1'b0;
  logic                         rst_ni;
  logic                         enable_i;
  logic                         vsync_pol_i;
  logic                         vsync_i;
  logic [NumBufs*AddrWidth-1:0] buf_base_i;
  logic                         flip_req_i;
  logic [IdxWidth-1:0]          flip_idx_i;
  logic [AddrWidth-1:0]         start_addr_o;
  logic                         fetch_en_o;
  logic                         frame_start_o;
  logic [IdxWidth-1:0]          disp_idx_o;
  logic                         pending_o;
  logic                         flip_done_o;
  logic                         flip_drop_o;
  logic                         idx_err_o;
  logic [FrameCntWidth-1:0]     frame_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_drop  = 0;
  int n_err   = 0;
  int ecnt    = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];

  axi_vga_flip_ctrl #(
    .AddrWidth     (AddrWidth),
    .NumBufs       (NumBufs),
    .IdxWidth      (IdxWidth),
    .FrameCntWidth (FrameCntWidth)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .vsync_pol_i   (vsync_pol_i),
    .vsync_i       (vsync_i),
    .buf_base_i    (buf_base_i),
    .flip_req_i    (flip_req_i),
    .flip_idx_i    (flip_idx_i),
    .start_addr_o  (start_addr_o),
    .fetch_en_o    (fetch_en_o),
    .frame_start_o (frame_start_o),
    .disp_idx_o    (disp_idx_o),
    .pending_o     (pending_o),
    .flip_done_o   (flip_done_o),
    .flip_drop_o   (flip_drop_o),
    .idx_err_o     (idx_err_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      n_done = n_done + int'(flip_done_o);
      n_drop = n_drop + int'(flip_drop_o);
      n_err  = n_err + int'(idx_err_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] observe(input string tag);
    case (tag)
      "start":  return start_addr_o;
      "fetch":  return 64'(fetch_en_o);
      "fstart": return 64'(frame_start_o);
      "disp":   return 64'(disp_idx_o);
      "pend":   return 64'(pending_o);
      "done":   return 64'(flip_done_o);
      "drop":   return 64'(flip_drop_o);
      "err":    return 64'(idx_err_o);
      "cnt":    return 64'(frame_cnt_o);
      "n_done": return 64'(n_done);
      "n_drop": return 64'(n_drop);
      "n_err":  return 64'(n_err);
      default:  return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.tag), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    enable_i    = 1'b0;
    vsync_pol_i = 1'b1;
    vsync_i     = 1'b0;
    flip_req_i  = 1'b0;
    flip_idx_i  = '0;
    buf_base_i  = {64'h8020_0000, 64'h8010_0000, 64'h8000_0000};
    #12;
    push("start", 0); push("fetch", 0); push("fstart", 0); push("disp", 0);
    push("pend", 0); push("cnt", 0); push("done", 0);
    drain();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(); tick();
    enable_i = 1'b1;
    tick();

    // First frame
    vsync_i = 1'b1; tick(); ecnt++;
    push("fetch", 1); push("fstart", 1); push("start", 64'h8000_0000);
    push("cnt", 64'(ecnt)); push("disp", 0); push("pend", 0);
    drain();
    vsync_i = 1'b0; tick();
    push("fstart", 0); drain();
    tick(); tick();

    // Simple flip to buffer 1
    flip_req_i = 1'b1; flip_idx_i = 2'd1; tick(); flip_req_i = 1'b0;
    push("pend", 1); push("drop", 0); push("disp", 0); drain();
    tick();
    vsync_i = 1'b1; tick(); ecnt++;
    push("disp", 1); push("start", 64'h8010_0000); push("done", 1);
    push("pend", 0); push("cnt", 64'(ecnt)); drain();
    vsync_i = 1'b0; tick();
    push("done", 0); drain();

    // Two requests in one frame: latest wins, one drop; same-index flip still completes
    flip_req_i = 1'b1; flip_idx_i = 2'd2; tick();
    flip_idx_i = 2'd1; tick(); flip_req_i = 1'b0;
    push("drop", 1); push("pend", 1); drain();
    tick();
    push("drop", 0); drain();
    vsync_i = 1'b1; tick(); ecnt++;
    push("disp", 1); push("start", 64'h8010_0000); push("done", 1); push("pend", 0);
    drain();
    vsync_i = 1'b0; tick();

    // Out-of-range index
    flip_req_i = 1'b1; flip_idx_i = 2'd3; tick(); flip_req_i = 1'b0;
    push("err", 1); push("pend", 0); push("disp", 1); drain();
    tick();
    push("err", 0); drain();

    // Mid-frame base change is not visible until the next boundary
    buf_base_i[63:0] = 64'h9000_0000; tick();
    push("start", 64'h8010_0000); drain();

    // Request coincident with a boundary and nothing pending
    vsync_i = 1'b1; flip_req_i = 1'b1; flip_idx_i = 2'd0; tick(); flip_req_i = 1'b0; ecnt++;
    push("done", 0); push("pend", 1); push("drop", 0); push("fstart", 1);
    push("disp", 1); push("cnt", 64'(ecnt)); drain();
    vsync_i = 1'b0; tick(); tick();
    vsync_i = 1'b1; tick(); ecnt++;
    push("disp", 0); push("start", 64'h9000_0000); push("done", 1); push("pend", 0);
    drain();
    vsync_i = 1'b0; tick();

    // Frame counter wrap at 4 bits
    while (ecnt < 16) begin
      vsync_i = 1'b1; tick(); ecnt++;
      vsync_i = 1'b0; tick(); tick();
    end
    push("cnt", 0); push("disp", 0); push("fetch", 1); drain();

    // Disable with a flip pending
    flip_req_i = 1'b1; flip_idx_i = 2'd2; tick(); flip_req_i = 1'b0;
    push("pend", 1); drain();
    enable_i = 1'b0; tick();
    push("fetch", 0); push("pend", 0); push("done", 0); push("disp", 0); push("cnt", 0);
    drain();

    // Disabled: vsync and requests ignored
    flip_req_i = 1'b1; flip_idx_i = 2'd1; vsync_i = 1'b1; tick(); flip_req_i = 1'b0;
    push("pend", 0); push("fstart", 0); push("err", 0); drain();
    tick();
    push("cnt", 0); push("fetch", 0); drain();
    vsync_i = 1'b0; tick();

    // Active-low vsync: boundary on the falling edge of vsync_i
    vsync_i = 1'b1; vsync_pol_i = 1'b0; tick();
    enable_i = 1'b1; tick(); tick();
    push("fetch", 0); push("fstart", 0); drain();
    vsync_i = 1'b0; tick();
    push("fetch", 1); push("fstart", 1); push("cnt", 1); push("disp", 0);
    push("start", 64'h9000_0000); drain();
    vsync_i = 1'b1; tick();
    push("fstart", 0); push("cnt", 1); drain();

    // Asynchronous reset mid-operation
    flip_req_i = 1'b1; flip_idx_i = 2'd2; tick(); flip_req_i = 1'b0;
    push("pend", 1); drain();
    #3 rst_ni = 1'b0;
    #1;
    push("fetch", 0); push("start", 0); push("pend", 0); push("cnt", 0); push("disp", 0);
    drain();

    push("n_done", 3); push("n_drop", 1); push("n_err", 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
